// File: rtl/wlo_host_pkg.sv
// Shared opcodes, reply length and FSM state type for the word-length-optimisation host.
package wlo_host_pkg;

    localparam logic [7:0] OP_SOFT_RST = 8'h01;
    localparam logic [7:0] OP_CONFIG   = 8'h02;
    localparam logic [7:0] OP_START    = 8'h03;

    localparam int unsigned MSE_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND_RST,
        SEND_CFG,
        SEND_START,
        RECV
    } state_t;

endpackage

// File: rtl/tx_pacer.sv
// Byte-gap down-counter: fire is high when the counter is idle at zero; load restarts the gap.
module tx_pacer #(
    parameter int unsigned BYTE_GAP = 9000
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic fire
);

    localparam int unsigned CNT_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(BYTE_GAP - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign fire = (cnt_q == '0);

endmodule

// File: rtl/mse_sweep_host.sv
// Host-side MSE measurement driver: sends SOFT_RST, CONFIG and START over the UART byte
// interface, then assembles the 8-byte little-endian MSE reply with a receive timeout.
module mse_sweep_host
    import wlo_host_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 3,
    parameter int unsigned BYTE_GAP = 9000,
    parameter int unsigned TIMEOUT  = 2**24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  go,
    input  logic [8*NUM_CHAN-1:0] cfg_int,
    input  logic [8*NUM_CHAN-1:0] cfg_frac,
    output logic                  com_txvalid,
    output logic [7:0]            com_txdata,
    input  logic                  com_rxvalid,
    input  logic [7:0]            com_rxdata,
    output logic                  busy,
    output logic [63:0]           mse_data,
    output logic                  mse_valid,
    output logic                  timeout_err
);

    localparam int unsigned CFG_W     = 8 * NUM_CHAN;
    localparam int unsigned CFG_BYTES = 2 * NUM_CHAN;
    localparam int unsigned IDX_W     = $clog2(CFG_BYTES + 1);
    localparam int unsigned TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RX_W      = $clog2(MSE_BYTES);

    state_t             state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic [63:0]        mse_data_q, mse_data_d;
    logic               mse_valid_q, mse_valid_d;
    logic               to_err_q, to_err_d;
    logic [CFG_W-1:0]   cfg_int_q, cfg_int_d;
    logic [CFG_W-1:0]   cfg_frac_q, cfg_frac_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RX_W-1:0]    rx_cnt_q, rx_cnt_d;
    logic [63:0]        sreg_q, sreg_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               pacer_load_c;
    logic               pacer_fire;
    logic [7:0]         cfg_byte_c;

    tx_pacer #(
        .BYTE_GAP (BYTE_GAP)
    ) u_tx_pacer (
        .clk  (clk),
        .rstn (rstn),
        .load (pacer_load_c),
        .fire (pacer_fire)
    );

    // Config byte order is int0, frac0, int1, frac1, ...
    always_comb begin
        cfg_byte_c = idx_q[0] ? cfg_frac_q[8*int'(idx_q >> 1) +: 8]
                              : cfg_int_q[8*int'(idx_q >> 1) +: 8];
    end

    // Each transition emits the first byte of the state being entered, so SOFT_RST
    // leaves on the same edge that accepts go.
    always_comb begin
        state_d      = state_q;
        tx_valid_d   = 1'b0;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        mse_data_d   = mse_data_q;
        mse_valid_d  = 1'b0;
        to_err_d     = 1'b0;
        cfg_int_d    = cfg_int_q;
        cfg_frac_d   = cfg_frac_q;
        idx_d        = idx_q;
        rx_cnt_d     = rx_cnt_q;
        sreg_d       = sreg_q;
        to_cnt_d     = to_cnt_q;
        pacer_load_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    cfg_int_d    = cfg_int;
                    cfg_frac_d   = cfg_frac;
                    rx_cnt_d     = '0;
                    busy_d       = 1'b1;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = OP_SOFT_RST;
                    pacer_load_c = 1'b1;
                    state_d      = SEND_RST;
                end
            end
            SEND_RST: begin
                if (pacer_fire) begin
                    tx_valid_d   = 1'b1;
                    tx_data_d    = OP_CONFIG;
                    pacer_load_c = 1'b1;
                    idx_d        = '0;
                    state_d      = SEND_CFG;
                end
            end
            SEND_CFG: begin
                if (pacer_fire) begin
                    tx_valid_d   = 1'b1;
                    tx_data_d    = cfg_byte_c;
                    pacer_load_c = 1'b1;
                    if (idx_q == IDX_W'(CFG_BYTES - 1)) begin
                        state_d = SEND_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SEND_START: begin
                if (pacer_fire) begin
                    tx_valid_d   = 1'b1;
                    tx_data_d    = OP_START;
                    pacer_load_c = 1'b1;
                    to_cnt_d     = '0;
                    rx_cnt_d     = '0;
                    state_d      = RECV;
                end
            end
            RECV: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (com_rxvalid) begin
                    sreg_d[8*int'(rx_cnt_q) +: 8] = com_rxdata;
                    to_cnt_d = '0;
                    if (rx_cnt_q == RX_W'(MSE_BYTES - 1)) begin
                        mse_data_d  = sreg_d;
                        mse_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        rx_cnt_d = rx_cnt_q + RX_W'(1);
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    to_err_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            mse_data_q  <= '0;
            mse_valid_q <= 1'b0;
            to_err_q    <= 1'b0;
            cfg_int_q   <= '0;
            cfg_frac_q  <= '0;
            idx_q       <= '0;
            rx_cnt_q    <= '0;
            sreg_q      <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            mse_data_q  <= mse_data_d;
            mse_valid_q <= mse_valid_d;
            to_err_q    <= to_err_d;
            cfg_int_q   <= cfg_int_d;
            cfg_frac_q  <= cfg_frac_d;
            idx_q       <= idx_d;
            rx_cnt_q    <= rx_cnt_d;
            sreg_q      <= sreg_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign com_txvalid = tx_valid_q;
    assign com_txdata  = tx_data_q;
    assign busy        = busy_q;
    assign mse_data    = mse_data_q;
    assign mse_valid   = mse_valid_q;
    assign timeout_err = to_err_q;

endmodule

// File: doc/mse_sweep_host.md
# mse_sweep_host

Host-side counterpart of the word-length-optimisation control unit: drives the command byte stream that configures and starts one MSE measurement, then assembles the 64-bit MSE reply. Sits between a user/sweep sequencer and a `uart_transmitter`/`uart_receiver` pair whose serial lines cross-connect to the DUT board. This lets a second FPGA, or a synthesizable bench, run word-length sweeps without a PC.

## Interface
- `NUM_CHAN`, 3: number of bit_switch channels configured per run.
- `BYTE_GAP`, 9000: cycles between successive `com_txvalid` pulses. Must be ≥ one UART frame (10 bit times).
- `TIMEOUT`, 2**24: maximum cycles spent in RECV before aborting.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `go` in 1: start one measurement. Sampled only in IDLE.
- `cfg_int` in 8×NUM_CHAN: integer bits per channel, latched on accepted `go`.
- `cfg_frac` in 8×NUM_CHAN: fractional bits per channel, latched on accepted `go`.
- `com_txvalid` out 1: one-cycle byte strobe to `uart_transmitter`.
- `com_txdata` out 8: byte to transmit, valid with `com_txvalid`.
- `com_rxvalid` in 1: one-cycle received-byte strobe from `uart_receiver`.
- `com_rxdata` in 8: received byte.
- `busy` out 1: high from accepted `go` until the return to IDLE.
- `mse_data` out 64: assembled MSE. Holds its value until the next completed run.
- `mse_valid` out 1: one-cycle pulse when `mse_data` updates.
- `timeout_err` out 1: one-cycle pulse on RECV timeout.

## Operation
- Opcodes:
  - 0x01 SOFT_RST.
  - 0x02 CONFIG, followed by 2·NUM_CHAN bytes in the order int0, frac0, int1, frac1, ….
  - 0x03 START.
- The reply is 8 bytes, LSB first.
- FSM states: IDLE → SEND_RST → SEND_CFG → SEND_START → RECV → IDLE.
- IDLE with `go`=1:
  - latch the cfg arrays;
  - clear the rx byte count;
  - assert `busy`;
  - enter SEND_RST.
- Each SEND state emits its bytes through a gap counter. A byte fires when the counter is 0; the counter then reloads to BYTE_GAP−1 and decrements each cycle. SEND_CFG emits 1+2·NUM_CHAN bytes in sequence.
- After the START byte, enter RECV. The gap counter does not gate RECV.
- RECV:
  - each `com_rxvalid` shifts `com_rxdata` into byte position `rx_cnt`;
  - on the 8th byte, copy the shift register to `mse_data`, pulse `mse_valid`, go to IDLE.
- RECV timeout: a counter clears on RECV entry and on every rx byte. When it reaches TIMEOUT−1: pulse `timeout_err`, leave `mse_data` unchanged, go to IDLE.
- `com_rxvalid` outside RECV is ignored. Stray bytes are never buffered.
- `go` while `busy` is ignored. It is not queued.
- Reset asserted mid-run: all state returns to reset values immediately. No partial frame is completed.

## Timing
- Reset values:
  - `com_txvalid`=0, `com_txdata`=0;
  - `busy`=0;
  - `mse_data`=0, `mse_valid`=0;
  - `timeout_err`=0;
  - FSM=IDLE, gap counter=0.
- `go` sampled at edge N: `busy`=1 and the 0x01 strobe both appear at edge N+1.
- Byte k (0-based) of a run is strobed at edge N+1+k·BYTE_GAP.
- Total bytes sent per run: 3+2·NUM_CHAN. That is 9 for NUM_CHAN=3, so the START byte lands at N+1+8·BYTE_GAP.
- All outputs are registered. `com_txdata` is stable only during the `com_txvalid` cycle and holds its last value otherwise.
- 8th rx byte at edge M:
  - `mse_valid`=1 and the new `mse_data` appear at edge M+1;
  - `busy`=0 at M+1;
  - a `go` at M+1 is accepted.
- A simultaneous `com_rxvalid` and timeout expiry counts as a received byte; the timeout does not fire.

## Structure
- Package `wlo_host_pkg` holds:
  - the opcode localparams OP_SOFT_RST, OP_CONFIG, OP_START;
  - MSE_BYTES=8;
  - the `state_t` enum.
- Sub-module `tx_pacer`: BYTE_GAP down-counter with `fire` output and `load` input. It is reused by the sweep sequencer.
- Everything else (FSM, byte mux, rx shifter, timeout counter) stays in `mse_sweep_host`.

## Test plan
- Reset, then `go` with int={2,2,5}, frac={10,11,20}, BYTE_GAP=16 → tx stream 01 02 02 0A 02 0B 05 14 03, strobes exactly 16 cycles apart, first strobe one cycle after `go`.
- After START, inject rx bytes 88 77 66 55 44 33 22 11 → `mse_data`=0x1122334455667788, one-cycle `mse_valid`, `busy` falls the same cycle.
- Inject only 5 rx bytes with TIMEOUT=100 → `timeout_err` pulse 100 cycles after the 5th byte, `mse_data` still holds the previous value, next `go` accepted.
- Pulse `go` during SEND_CFG and inject rx bytes during SEND_RST → stream unchanged, rx count unaffected.
- Assert `rstn` low mid-RECV after 3 bytes → all outputs at reset values. A fresh run then completes normally.
- Back-to-back: `go` held high continuously → second run's 0x01 is strobed one cycle after the first run's `mse_valid`.
